game_timer_score: RTL

//  Game-control stage directly upstream of the 4-digit 7-seg scanner.

---
 rtl/game_timer_score_pkg.sv | 23 ++
 rtl/game_timer_score_tick_gen.sv | 47 ++++
 rtl/game_timer_score.sv | 125 ++++++++++++
 3 files changed

// File: rtl/game_timer_score_pkg.sv
// Shared definitions for the round timer / score stage: counter widths,
// FSM state encodings, default prescaler divide and small counter helpers.
package game_timer_score_pkg;

  localparam int CNT_W        = 6;
  localparam int SCORE_W      = 5;
  localparam int TICK_DIV_DEF = 50_000_000;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_RUN  = 2'd1;
  localparam logic [1:0] ST_OVER = 2'd2;

  // Increment that sticks at max_v instead of wrapping.
  function automatic logic [SCORE_W-1:0] sat_inc(input logic [SCORE_W-1:0] v,
                                                 input logic [SCORE_W-1:0] max_v);
    if (v >= max_v) begin
      return max_v;
    end else begin
      return v + 5'd1;
    end
  endfunction

endpackage

// File: rtl/game_timer_score_tick_gen.sv
// tick_gen: free-running prescaler that counts 0..TICK_DIV-1 while en is high
// and flags the wrap cycle with a one-cycle tick. clr restarts it from zero.
// Also used by the display scan-rate divider.
module tick_gen #(
  parameter int TICK_DIV = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic en,
  input  logic clr,
  output logic tick
);

  localparam int CW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [CW-1:0] LAST = CW'(TICK_DIV - 1);

  logic [CW-1:0] cnt_q;
  logic [CW-1:0] cnt_d;

  // Next prescaler value: clear wins, otherwise count and wrap while enabled.
  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = {CW{1'b0}};
    end else if (en) begin
      if (cnt_q == LAST) begin
        cnt_d = {CW{1'b0}};
      end else begin
        cnt_d = cnt_q + CW'(1);
      end
    end else begin
      cnt_d = cnt_q;
    end
  end

  // Prescaler register with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst) begin
      cnt_q <= {CW{1'b0}};
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign tick = en & ~clr & (cnt_q == LAST);

endmodule

// File: rtl/game_timer_score.sv
// game_timer_score: round FSM (IDLE/RUN/OVER), per-round seconds countdown
// and saturating hit score feeding the 7-seg scanner.
// Optional feature macro: PAUSE_EN -- when defined, pause==1 in RUN freezes
// the prescaler and the countdown (hits still count). When undefined the
// pause input is accepted but has no effect.
module game_timer_score
  import game_timer_score_pkg::*;
#(
  parameter int TICK_DIV     = TICK_DIV_DEF,
  parameter int GAME_SECONDS = 60,
  parameter int SCORE_MAX    = 19
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic         hit,
  input  logic         pause,
  output logic [5:0]   cnttime,
  output logic [4:0]   score,
  output logic         running,
  output logic         game_over
);

  localparam logic [CNT_W-1:0]   LOAD_VAL  = CNT_W'(GAME_SECONDS);
  localparam logic [SCORE_W-1:0] SCORE_TOP = SCORE_W'(SCORE_MAX);

  logic [1:0]         state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [SCORE_W-1:0] score_q, score_d;
  logic               running_q, game_over_q;
  logic               start_q, hit_q;
  logic               start_rise_s, hit_rise_s;
  logic               tick_s, tick_en_s, tick_clr_s;

  assign start_rise_s = start & ~start_q;
  assign hit_rise_s   = hit & ~hit_q;

`ifdef PAUSE_EN
  assign tick_en_s = (state_q == ST_RUN) & ~pause;
`else
  logic unused_pause_s;
  assign unused_pause_s = pause;
  assign tick_en_s      = (state_q == ST_RUN);
`endif

  // Prescaler restarts on every round start so the first second is full length.
  assign tick_clr_s = start_rise_s & (state_q != ST_RUN);

  tick_gen #(
    .TICK_DIV(TICK_DIV)
  ) u_tick_gen (
    .clk (clk),
    .rst (rst),
    .en  (tick_en_s),
    .clr (tick_clr_s),
    .tick(tick_s)
  );

  // Round FSM plus timer/score next-state; start from IDLE or OVER reloads.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    score_d = score_q;
    case (state_q)
      ST_IDLE, ST_OVER: begin
        if (start_rise_s) begin
          state_d = ST_RUN;
          cnt_d   = LOAD_VAL;
          score_d = {SCORE_W{1'b0}};
        end else begin
          state_d = state_q;
        end
      end
      ST_RUN: begin
        if (tick_s) begin
          if (cnt_q <= 6'd1) begin
            cnt_d   = {CNT_W{1'b0}};
            state_d = ST_OVER;
          end else begin
            cnt_d = cnt_q - 6'd1;
          end
        end else begin
          cnt_d = cnt_q;
        end
        if (hit_rise_s) begin
          score_d = sat_inc(score_q, SCORE_TOP);
        end else begin
          score_d = score_q;
        end
      end
      default: begin
        state_d = ST_IDLE;
        cnt_d   = LOAD_VAL;
        score_d = {SCORE_W{1'b0}};
      end
    endcase
  end

  // State, counters, decoded status flags and edge-detect history.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q     <= ST_IDLE;
      cnt_q       <= LOAD_VAL;
      score_q     <= {SCORE_W{1'b0}};
      running_q   <= 1'b0;
      game_over_q <= 1'b0;
      start_q     <= 1'b0;
      hit_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      score_q     <= score_d;
      running_q   <= (state_d == ST_RUN);
      game_over_q <= (state_d == ST_OVER);
      start_q     <= start;
      hit_q       <= hit;
    end
  end

  assign cnttime   = cnt_q;
  assign score     = score_q;
  assign running   = running_q;
  assign game_over = game_over_q;

endmodule
